cmlk_param_commit: RTL and testbench
====================================

// Module: cmlk_param_commit
// PURPOSE
//  Upstream stage of the CMLK timing controller: stages a full timing-parameter set on a commit
//  request, range-checks it, waits for a safe frame boundary (falling edge of frame_ext_trig),
//  then presents the set and pulses load_param so the timing controller swaps atomically.
//  Stops illegal or mid-frame parameter changes from reaching the pulse generators.
// PARAMETERS
//  SYNC_STAGES     2            synchroniser depth for frame_ext_trig (>=2)
//  LOAD_HOLD       4            cycles load_param stays high (lets the 100 MHz derived domain sample it)
//  TIMEOUT_CYCLES  100000000    WAIT cycles before a forced load when no frame edge arrives (32-bit)
// PORTS
//  clk                 in   1   system clock; only clock of the block
//  rst                 in   1   synchronous reset, active-high
//  commit_req          in   1   single-cycle request to commit the *_i values
//  cmos_freq_i         in   16  staged cmos trigger period
//  cmos_width_i        in   16  staged cmos trigger width
//  laser_freq_i        in   32  staged laser period
//  laser_width_i       in   32  staged laser width
//  gate_width_a_i      in   32  staged frame-A gate width
//  gate_delay_a_i      in   32  staged frame-A gate delay
//  gate_width_b_i      in   32  staged frame-B gate width
//  gate_delay_b_i      in   32  staged frame-B gate delay
//  tim_cycles_m_i      in   8   staged cycles per delay step
//  delay_step_i        in   8   staged delay step delta-t
//  bg_deci_n_i         in   16  staged background-frame decimation
//  frame_ext_trig      in   1   frame trigger from timing controller (async to clk)
//  clock_locked        in   1   timing-controller PLL lock
//  cmos_freq ... bg_frame_deci_n  out  (same widths)  committed parameter set, registered
//  load_param          out  1   load strobe to timing controller
//  busy                out  1   high from accept until commit_done
//  commit_done         out  1   1-cycle pulse: set applied
//  commit_drop         out  1   1-cycle pulse: commit_req arrived while busy (ignored)
//  err_valid           out  1   1-cycle pulse: staged set rejected
//  err_code            out  6   reason bits, held until next accepted request
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, staging regs 0, timeout counter 0, synchroniser cleared.
//  FSM: IDLE -> CHECK -> (REJECT | WAIT) ; WAIT -> APPLY -> PULSE -> DONE -> IDLE; REJECT -> IDLE.
//  IDLE: commit_req at cycle T captures all *_i into staging regs; busy=1 from T+1; err_code cleared.
//  CHECK (T+1): evaluate, 1 cycle; any bit set -> REJECT, err_valid=1 at T+2 with err_code.
//   err_code[0] cmos_freq==0 or cmos_width==0 or cmos_width>=cmos_freq
//   err_code[1] laser_freq==0 or laser_width==0 or laser_width>=laser_freq
//   err_code[2] gate_delay_a+gate_width_a > laser_freq (33-bit sum, no wrap)
//   err_code[3] gate_delay_b+gate_width_b > laser_freq (33-bit sum)
//   err_code[4] tim_cycles_m==0
//   err_code[5] bg_deci_n==0
//  REJECT: busy drops the same cycle err_valid pulses; committed outputs unchanged.
//  WAIT: frame_ext_trig through SYNC_STAGES flops + 1 edge register; falling edge (prev=1,cur=0)
//   -> APPLY next cycle. Forced exit to APPLY when clock_locked==0 (controller idle) or timeout
//   counter reaches TIMEOUT_CYCLES-1; counter cleared on entry to WAIT.
//  APPLY: committed outputs <= staging regs (1 cycle). PULSE: load_param=1 for LOAD_HOLD cycles,
//   committed outputs stable throughout. DONE: commit_done=1 one cycle, busy=0 same cycle.
//  commit_req while busy: ignored, commit_drop pulses next cycle; staging regs untouched.
//  commit_req in the DONE/REJECT cycle counts as busy (dropped). Back-to-back accept from IDLE only.
//  Edge present on the same cycle as WAIT entry: honoured (edge register runs continuously).
//  rst mid-operation: immediate return to IDLE; load_param drops next edge; committed set -> 0.
// TESTING
//  Legal set (cmos 1000/100, laser 500/20, A 100+50, B 200+50, m=4, n=8), commit, fall edge at E ->
//   outputs update E+1, load_param high E+2..E+5, commit_done at E+6, busy 0.
//  cmos_width=1000, cmos_freq=1000 -> err_valid at T+2, err_code=6'b000001, no load_param.
//  gate_delay_a=32'hFFFF_FFF0, width_a=32'h20, laser 500 -> err_code[2]=1 (no 32-bit wrap pass).
//  frame_ext_trig held low, TIMEOUT_CYCLES=64 -> APPLY after 64 WAIT cycles, load_param follows.
//  Second commit_req during WAIT -> commit_drop 1 cycle; first set committed, second ignored.
//  rst asserted during PULSE -> load_param 0 and all outputs 0 after one clk; next commit works.

Source files
------------

// File: rtl/cmlk_param_commit.sv
// cmlk_param_commit: stages a timing-parameter set, range-checks it, waits for a
// falling frame trigger (or a forced exit), then presents the set and strobes
// load_param so the downstream timing controller swaps atomically.
module cmlk_param_commit #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned LOAD_HOLD      = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_req,
  input  logic [15:0] cmos_freq_i,
  input  logic [15:0] cmos_width_i,
  input  logic [31:0] laser_freq_i,
  input  logic [31:0] laser_width_i,
  input  logic [31:0] gate_width_a_i,
  input  logic [31:0] gate_delay_a_i,
  input  logic [31:0] gate_width_b_i,
  input  logic [31:0] gate_delay_b_i,
  input  logic [7:0]  tim_cycles_m_i,
  input  logic [7:0]  delay_step_i,
  input  logic [15:0] bg_deci_n_i,
  input  logic        frame_ext_trig,
  input  logic        clock_locked,
  output logic [15:0] cmos_freq,
  output logic [15:0] cmos_width,
  output logic [31:0] laser_freq,
  output logic [31:0] laser_width,
  output logic [31:0] gate_width_a,
  output logic [31:0] gate_delay_a,
  output logic [31:0] gate_width_b,
  output logic [31:0] gate_delay_b,
  output logic [7:0]  tim_cycles_m,
  output logic [7:0]  delay_step,
  output logic [15:0] bg_frame_deci_n,
  output logic        load_param,
  output logic        busy,
  output logic        commit_done,
  output logic        commit_drop,
  output logic        err_valid,
  output logic [5:0]  err_code
);

  typedef struct packed {
    logic [15:0] cmos_freq;
    logic [15:0] cmos_width;
    logic [31:0] laser_freq;
    logic [31:0] laser_width;
    logic [31:0] gate_width_a;
    logic [31:0] gate_delay_a;
    logic [31:0] gate_width_b;
    logic [31:0] gate_delay_b;
    logic [7:0]  tim_cycles_m;
    logic [7:0]  delay_step;
    logic [15:0] bg_deci_n;
  } param_t;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_REJECT, S_WAIT, S_APPLY, S_PULSE, S_DONE
  } state_t;

  localparam logic [31:0] HOLD_LAST = 32'(LOAD_HOLD - 1);
  localparam logic [31:0] TMO_LAST  = TIMEOUT_CYCLES - 32'd1;

  state_t                 state_q, state_d;
  logic [31:0]            cnt_q, cnt_d;
  param_t                 stg_q, com_q, in_p;
  logic [5:0]             err_code_q, chk;
  logic                   drop_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   trig_prev_q;
  logic                   fall;
  logic [32:0]            sum_a, sum_b;

  assign in_p = {cmos_freq_i, cmos_width_i, laser_freq_i, laser_width_i,
                 gate_width_a_i, gate_delay_a_i, gate_width_b_i, gate_delay_b_i,
                 tim_cycles_m_i, delay_step_i, bg_deci_n_i};

  // Edge register runs continuously so an edge on the WAIT entry cycle is seen.
  assign fall = trig_prev_q & ~sync_q[SYNC_STAGES-1];

  // Range check of the staged set; gate sums are 33-bit so they cannot wrap.
  always_comb begin
    sum_a  = {1'b0, stg_q.gate_delay_a} + {1'b0, stg_q.gate_width_a};
    sum_b  = {1'b0, stg_q.gate_delay_b} + {1'b0, stg_q.gate_width_b};
    chk[0] = (stg_q.cmos_freq == '0) || (stg_q.cmos_width == '0) ||
             (stg_q.cmos_width >= stg_q.cmos_freq);
    chk[1] = (stg_q.laser_freq == '0) || (stg_q.laser_width == '0) ||
             (stg_q.laser_width >= stg_q.laser_freq);
    chk[2] = sum_a > {1'b0, stg_q.laser_freq};
    chk[3] = sum_b > {1'b0, stg_q.laser_freq};
    chk[4] = (stg_q.tim_cycles_m == '0);
    chk[5] = (stg_q.bg_deci_n == '0);
  end

  // Next state; cnt counts WAIT (timeout) and PULSE (hold) cycles, zero on entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_IDLE:   if (commit_req) state_d = S_CHECK;
      S_CHECK:  state_d = (chk != '0) ? S_REJECT : S_WAIT;
      S_REJECT: state_d = S_IDLE;
      S_WAIT: begin
        if (fall || !clock_locked || (cnt_q == TMO_LAST)) state_d = S_APPLY;
        else cnt_d = cnt_q + 32'd1;
      end
      S_APPLY:  state_d = S_PULSE;
      S_PULSE: begin
        if (cnt_q == HOLD_LAST) state_d = S_DONE;
        else cnt_d = cnt_q + 32'd1;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, counter, trigger synchroniser and drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sync_q      <= '0;
      trig_prev_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], frame_ext_trig};
      trig_prev_q <= sync_q[SYNC_STAGES-1];
      drop_q      <= commit_req && (state_q != S_IDLE);
    end
  end

  // Staging capture on accept, error latch at CHECK, committed set loaded on the
  // WAIT->APPLY edge so it is stable for a full cycle before load_param rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_q      <= '0;
      com_q      <= '0;
      err_code_q <= '0;
    end else begin
      if (state_q == S_IDLE && commit_req) begin
        stg_q      <= in_p;
        err_code_q <= '0;
      end
      if (state_q == S_CHECK) err_code_q <= chk;
      if (state_q == S_WAIT && state_d == S_APPLY) com_q <= stg_q;
    end
  end

  assign busy        = (state_q == S_CHECK) || (state_q == S_WAIT) ||
                       (state_q == S_APPLY) || (state_q == S_PULSE);
  assign err_valid   = (state_q == S_REJECT);
  assign commit_done = (state_q == S_DONE);
  assign load_param  = (state_q == S_PULSE);
  assign commit_drop = drop_q;
  assign err_code    = err_code_q;

  assign cmos_freq       = com_q.cmos_freq;
  assign cmos_width      = com_q.cmos_width;
  assign laser_freq      = com_q.laser_freq;
  assign laser_width     = com_q.laser_width;
  assign gate_width_a    = com_q.gate_width_a;
  assign gate_delay_a    = com_q.gate_delay_a;
  assign gate_width_b    = com_q.gate_width_b;
  assign gate_delay_b    = com_q.gate_delay_b;
  assign tim_cycles_m    = com_q.tim_cycles_m;
  assign delay_step      = com_q.delay_step;
  assign bg_frame_deci_n = com_q.bg_deci_n;

endmodule

// File: tb/tb_cmlk_param_commit.sv
// Bench for cmlk_param_commit: scheduled stimulus pushes expected results into
// queues; a negedge monitor pops and compares whenever the DUT reports.
module tb_cmlk_param_commit;
  localparam int SYNC = 2;
  localparam int LH   = 4;
  localparam int TMO  = 64;

  typedef struct packed {
    logic [15:0] cmos_freq;
    logic [15:0] cmos_width;
    logic [31:0] laser_freq;
    logic [31:0] laser_width;
    logic [31:0] gate_width_a;
    logic [31:0] gate_delay_a;
    logic [31:0] gate_width_b;
    logic [31:0] gate_delay_b;
    logic [7:0]  tim_cycles_m;
    logic [7:0]  delay_step;
    logic [15:0] bg_deci_n;
  } param_t;

  typedef struct {
    int         cyc;
    bit         is_err;
    logic [5:0] code;
    param_t     outs;
  } res_t;

  logic clk = 0, rst = 1, req = 0, trig = 1, lock = 1;
  param_t pin = '0;
  logic [15:0] cmos_freq, cmos_width, bg_frame_deci_n;
  logic [31:0] laser_freq, laser_width, gate_width_a, gate_delay_a, gate_width_b, gate_delay_b;
  logic [7:0]  tim_cycles_m, delay_step;
  logic        load_param, busy, commit_done, commit_drop, err_valid;
  logic [5:0]  err_code;
  logic [255:0] obus;

  int tot = 0, bad = 0, cyc = 0, ld_cnt = 0;
  res_t   res_q[$];
  int     drop_q[$];
  param_t exp_com = '0;

  cmlk_param_commit #(.SYNC_STAGES(SYNC), .LOAD_HOLD(LH), .TIMEOUT_CYCLES(32'(TMO))) dut (
    .clk(clk), .rst(rst), .commit_req(req),
    .cmos_freq_i(pin.cmos_freq), .cmos_width_i(pin.cmos_width),
    .laser_freq_i(pin.laser_freq), .laser_width_i(pin.laser_width),
    .gate_width_a_i(pin.gate_width_a), .gate_delay_a_i(pin.gate_delay_a),
    .gate_width_b_i(pin.gate_width_b), .gate_delay_b_i(pin.gate_delay_b),
    .tim_cycles_m_i(pin.tim_cycles_m), .delay_step_i(pin.delay_step),
    .bg_deci_n_i(pin.bg_deci_n), .frame_ext_trig(trig), .clock_locked(lock),
    .cmos_freq(cmos_freq), .cmos_width(cmos_width), .laser_freq(laser_freq),
    .laser_width(laser_width), .gate_width_a(gate_width_a), .gate_delay_a(gate_delay_a),
    .gate_width_b(gate_width_b), .gate_delay_b(gate_delay_b), .tim_cycles_m(tim_cycles_m),
    .delay_step(delay_step), .bg_frame_deci_n(bg_frame_deci_n), .load_param(load_param),
    .busy(busy), .commit_done(commit_done), .commit_drop(commit_drop),
    .err_valid(err_valid), .err_code(err_code)
  );

  assign obus = {cmos_freq, cmos_width, laser_freq, laser_width, gate_width_a, gate_delay_a,
                 gate_width_b, gate_delay_b, tim_cycles_m, delay_step, bg_frame_deci_n};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference rules for rejecting a staged set.
  function automatic logic [5:0] model_err(input param_t p);
    logic [5:0] e;
    e[0] = (p.cmos_freq == 0) || (p.cmos_width == 0) || (p.cmos_width >= p.cmos_freq);
    e[1] = (p.laser_freq == 0) || (p.laser_width == 0) || (p.laser_width >= p.laser_freq);
    e[2] = (longint'(p.gate_delay_a) + longint'(p.gate_width_a)) > longint'(p.laser_freq);
    e[3] = (longint'(p.gate_delay_b) + longint'(p.gate_width_b)) > longint'(p.laser_freq);
    e[4] = (p.tim_cycles_m == 0);
    e[5] = (p.bg_deci_n == 0);
    return e;
  endfunction

  function automatic param_t rand_params();
    param_t p;
    int unsigned lf, v;
    p.cmos_freq    = 16'($urandom_range(4000, 2));
    p.cmos_width   = 16'($urandom_range(32'(p.cmos_freq) - 1, 1));
    lf             = $urandom_range(200000, 2);
    p.laser_freq   = lf;
    p.laser_width  = $urandom_range(lf - 1, 1);
    p.gate_width_a = $urandom_range(lf / 2, 0);
    p.gate_delay_a = $urandom_range(lf - p.gate_width_a, 0);
    p.gate_width_b = $urandom_range(lf / 2, 0);
    p.gate_delay_b = $urandom_range(lf - p.gate_width_b, 0);
    p.tim_cycles_m = 8'($urandom_range(255, 1));
    p.delay_step   = 8'($urandom);
    p.bg_deci_n    = 16'($urandom_range(65535, 1));
    v = $urandom_range(13, 0);
    case (v)
      5:  p.gate_delay_a = lf - p.gate_width_a;
      6:  p.cmos_width = p.cmos_freq;
      7:  p.cmos_freq = 0;
      8:  p.laser_width = lf;
      9:  begin p.gate_delay_a = 32'hFFFF_FFF0; p.gate_width_a = 32'h20; end
      10: p.gate_delay_b = lf - p.gate_width_b + 1;
      11: p.tim_cycles_m = 0;
      12: p.bg_deci_n = 0;
      13: p.laser_width = 0;
      default: ;
    endcase
    return p;
  endfunction

  // mode 0: trigger falls in cycle T+k; 1: trigger held low -> timeout; 2: PLL unlocked.
  task automatic run_commit(input param_t p, input int mode, input int k, input bit drop_en);
    logic [5:0] e;
    int T, fin, dc;
    res_t r;
    if (mode == 1) begin trig = 0; repeat (4) tick(); end
    T = cyc;
    e = model_err(p);
    pin = p; req = 1;
    if (mode == 2) lock = 0;
    if (mode == 0 && k == 0) trig = 0;
    if (e != 0) begin
      fin = T + 2;
      r = '{T + 2, 1'b1, e, exp_com};
    end else begin
      fin = (mode == 0) ? T + k + SYNC : (mode == 1) ? T + 1 + TMO : T + 2;
      fin = fin + 2 + LH;
      exp_com = p;
      r = '{fin, 1'b0, 6'd0, p};
    end
    res_q.push_back(r);
    dc = T + 1 + int'($urandom_range(fin - T - 1, 0));
    if (drop_en) drop_q.push_back(dc + 1);
    tick();
    chk("busy_after_accept", 256'(busy), 256'(1));
    chk("err_code_cleared", 256'(err_code), 256'(0));
    while (1) begin
      req = drop_en && (cyc == dc);
      if (req) pin = rand_params();
      if (mode == 0 && cyc >= T + k) trig = 0;
      if (cyc >= fin) break;
      tick();
    end
    tick();
    req = 0; lock = 1; trig = 1;
    repeat (5) tick();
  endtask

  // Monitor: every reported event is matched against the scoreboard queues.
  always @(negedge clk) begin
    res_t r;
    if (rst) ld_cnt = 0;
    else begin
      if (load_param) ld_cnt++;
      if (commit_drop) begin
        if (drop_q.size() == 0) chk("unexpected_drop", 256'(1), 256'(0));
        else chk("drop_cycle", 256'(cyc), 256'(drop_q.pop_front()));
      end
      if (err_valid || commit_done) begin
        if (res_q.size() == 0) chk("unexpected_result", 256'(1), 256'(0));
        else begin
          r = res_q.pop_front();
          chk("result_kind", 256'({err_valid, commit_done}), 256'({r.is_err, !r.is_err}));
          chk("result_cycle", 256'(cyc), 256'(r.cyc));
          chk("result_outs", obus, r.outs);
          chk("busy_low_at_result", 256'(busy), 256'(0));
          if (r.is_err) begin
            chk("err_code", 256'(err_code), 256'(r.code));
            chk("no_load_on_reject", 256'(ld_cnt), 256'(0));
          end else chk("load_hold_len", 256'(ld_cnt), 256'(LH));
          ld_cnt = 0;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    param_t legal, p;
    int T, m;
    legal = '{16'd1000, 16'd100, 32'd500, 32'd20, 32'd50, 32'd100, 32'd50, 32'd200,
              8'd4, 8'd1, 16'd8};
    repeat (3) tick();
    chk("rst_outs", obus, 256'(0));
    chk("rst_ctl", 256'({load_param, busy, commit_done, commit_drop, err_valid, err_code}), 256'(0));
    rst = 0;
    repeat (5) tick();

    run_commit(legal, 0, 3, 1'b0);
    p = legal; p.cmos_width = 16'd1000;
    run_commit(p, 0, 2, 1'b0);
    p = legal; p.gate_delay_a = 32'hFFFF_FFF0; p.gate_width_a = 32'h20;
    run_commit(p, 0, 2, 1'b1);
    p = legal; p.delay_step = 8'd2; p.laser_width = 32'd21;
    run_commit(p, 1, 0, 1'b1);
    p = legal; p.bg_deci_n = 16'd9;
    run_commit(p, 2, 0, 1'b1);
    run_commit(legal, 0, 0, 1'b0);

    // Reset in the middle of the load pulse.
    p = legal; p.tim_cycles_m = 8'd7;
    T = cyc; pin = p; req = 1; lock = 0;
    tick(); req = 0;
    while (cyc < T + 5) tick();
    chk("load_in_pulse", 256'(load_param), 256'(1));
    rst = 1;
    tick();
    rst = 0;
    chk("rst_mid_outs", obus, 256'(0));
    chk("rst_mid_ctl", 256'({load_param, busy, commit_done, err_valid, err_code}), 256'(0));
    exp_com = '0; lock = 1;
    repeat (5) tick();
    run_commit(legal, 0, 1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      m = int'($urandom_range(5, 0));
      run_commit(rand_params(), (m < 4) ? 0 : (m == 4) ? 1 : 2,
                 int'($urandom_range(8, 0)), 1'($urandom_range(1, 0)));
    end

    repeat (10) tick();
    chk("res_queue_empty", 256'(res_q.size()), 256'(0));
    chk("drop_queue_empty", 256'(drop_q.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
